// File: rtl/fifo_arb_pkg.sv
// Shared types, default sizes and width helper for the sync_fifo write arbiter.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int unsigned DEF_NUM_REQ    = 4;
  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_BURST_LEN  = 4;

  // $clog2 that never returns less than 1, so a 1-bit field is always legal.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: first set request strictly after last_grant, wrapping.
module rr_priority_picker
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned IDX_W   = clog2_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  logic             hit_hi;
  logic             hit_lo;
  logic [IDX_W-1:0] idx_hi;
  logic [IDX_W-1:0] idx_lo;

  // Lowest index above last_grant wins; otherwise lowest index at or below it.
  always_comb begin
    hit_hi = 1'b0;
    hit_lo = 1'b0;
    idx_hi = '0;
    idx_lo = '0;
    for (int j = 0; j < int'(NUM_REQ); j++) begin
      if (req[j]) begin
        if (IDX_W'(j) > last_grant) begin
          if (!hit_hi) begin
            hit_hi = 1'b1;
            idx_hi = IDX_W'(j);
          end
        end else if (!hit_lo) begin
          hit_lo = 1'b1;
          idx_lo = IDX_W'(j);
        end
      end
    end
    found = hit_hi | hit_lo;
    idx   = hit_hi ? idx_hi : idx_lo;
  end

endmodule

// File: rtl/sync_fifo_wr_arbiter.sv
// Round-robin arbiter sharing one sync_fifo write port among NUM_REQ producers.
module sync_fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned BURST_LEN  = DEF_BURST_LEN
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic                             full,
  output logic                             w_en,
  output logic [DATA_WIDTH-1:0]            din,
  output logic [clog2_min1(NUM_REQ)-1:0]   grant_id,
  output logic                             busy
);

  localparam int unsigned IDX_W = clog2_min1(NUM_REQ);
  localparam int unsigned CNT_W = clog2_min1(BURST_LEN + 1);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  grant_id_q, grant_id_d;
  logic [IDX_W-1:0]  last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic              busy_q, busy_d;

  logic              pick_found;
  logic [IDX_W-1:0]  pick_idx;
  logic              accept;
  logic              last_beat;
  logic [DATA_WIDTH-1:0] req_word [NUM_REQ];

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .found      (pick_found),
    .idx        (pick_idx)
  );

  // Unpack the flat producer data bus into one word per producer.
  always_comb begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      req_word[i] = req_data[i*int'(DATA_WIDTH) +: DATA_WIDTH];
    end
  end

  // Data path has no register: the owner's word goes straight to the FIFO.
  assign din       = req_word[grant_id_q];
  assign last_beat = (beat_cnt_q == CNT_W'(BURST_LEN - 1));

  // Next-state, counters and the combinational write-side handshake.
  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    req_ready    = '0;
    accept       = 1'b0;
    w_en         = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_id_d = pick_idx;
          beat_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        req_ready[grant_id_q] = ~full;
        accept = req_valid[grant_id_q] & ~full;
        w_en   = accept;
        if (accept) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          // A word that is both last and the final beat ends the burst once.
          if (req_last[grant_id_q] || last_beat) begin
            state_d      = IDLE;
            last_grant_d = grant_id_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == GRANT);
  end

  // State register; reset hands producer 0 the first grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_id_q   <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      beat_cnt_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      busy_q       <= busy_d;
    end
  end

  assign grant_id = grant_id_q;
  assign busy     = busy_q;

endmodule
